seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Serial bit-pattern transmitter: the source end of the serial-bit sequence-detector interface.
//  Accepts a PAT_W-bit pattern over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
//  Repeats the pattern a programmed number of times, with a programmable gap between repetitions.
//  Used as on-chip stimulus for the sequence detector and as a standalone pattern source.
// PARAMETERS
//  PAT_W  4  pattern width in bits (>=2)
//  CNT_W  8  width of repeat_cnt
//  GAP_W  4  width of gap_len
// PORTS
//  clk            in   1      clock; all logic on posedge
//  rst            in   1      synchronous reset, active-high
//  ena            in   1      global enable; 0 freezes all registers
//  pat_valid      in   1      pattern request valid
//  pat_ready      out  1      1 = request accepted this cycle when pat_valid=1
//  pat_data       in   PAT_W  pattern; bit PAT_W-1 is sent first
//  repeat_cnt     in   CNT_W  extra repetitions (0 = send once)
//  gap_len        in   GAP_W  fill bits between repetitions (0 = back-to-back)
//  output_bit     out  1      serial data bit
//  bit_valid      out  1      output_bit is a line bit this cycle (pattern or gap)
//  in_pattern     out  1      output_bit belongs to the pattern, not the gap
//  done           out  1      one-cycle pulse after the final pattern bit
//  busy           out  1      state != IDLE
//  present_state  out  3      FSM state encoding, for debug/verification
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE(3'd0); output_bit, bit_valid, in_pattern, done, busy = 0.
//   All counters and the pattern register clear to 0. Reset overrides ena and pat_valid.
//  States: IDLE=0, SEND=1, GAP=2, DONE=3. Encodings 4-7 are illegal and go to IDLE next edge.
//  pat_ready = (state==IDLE) & ena & ~rst. This is combinational; it is 0 in SEND, GAP and DONE.
//  IDLE: on an accept edge (pat_valid & pat_ready):
//   - latch pat_data, repeat_cnt and gap_len;
//   - output_bit <= pat_data[PAT_W-1]; bit_valid <= 1; in_pattern <= 1; state <= SEND.
//   The first bit is therefore visible the cycle after accept.
//  SEND: shift MSB-first with a bit index counter (clog2(PAT_W) bits).
//   After bit 0 is presented:
//   - if repetitions remain and gap_len != 0, go to GAP;
//   - if repetitions remain and gap_len == 0, present the next pattern's MSB on the next cycle;
//   - if none remain, go to DONE.
//  GAP: present gap_len fill bits (bit_valid=1, in_pattern=0), then the pattern MSB again (SEND).
//  DONE: output_bit=0, bit_valid=0, in_pattern=0, done=1 for exactly one cycle, then IDLE.
//   pat_ready is 0 in DONE; a new request is accepted at the earliest in the following IDLE cycle.
//  Total line bits per request = (repeat_cnt+1)*PAT_W + repeat_cnt*gap_len.
//   The repeat counter decrements per completed pattern and is CNT_W wide; no wrap is possible.
//  ena=0: every register holds. The visible bit_valid is the registered value ANDed with ena,
//   so no bit is counted twice. Resuming ena re-presents the held bit for one valid cycle.
//  pat_valid while busy: ignored; pat_data may change freely while not accepted.
//  rst mid-transfer: abort to the IDLE reset values on that edge; no done pulse is produced.
// CONFIGURATION
//  SEQGEN_LFSR_FILL_EN defined:
//   - gap fill bits come from an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1;
//   - output is lfsr[7]; the shift direction is MSB-out, with the feedback bit entering at lfsr[0];
//   - seed 8'hA5 on reset; advances only on GAP cycles with ena=1; persists across requests.
//  Undefined: fill bits are constant 0; no LFSR logic is built.
//  Pattern bits, timing and handshake are identical in both builds.
// TESTING
//  1. rst=1 for 2 cycles, ena=1 -> all outputs 0 and present_state=0; pat_ready=1 on the first cycle with rst=0.
//  2. pat_data=4'b1010, repeat=0, gap=0 -> output_bit 1,0,1,0 over 4 cycles with bit_valid=1;
//     then done=1 for 1 cycle; state returns to 0.
//  3. 4'b1101, repeat=1, gap=2, no LFSR -> bits 1,1,0,1,0,0,1,1,0,1 (in_pattern 1111001111); then done.
//  4. 4'b1010, ena=0 for 3 cycles after the 2nd bit -> bit_valid=0 during the stall;
//     then bits 1,0 resume; exactly 4 valid bits total.
//  5. rst=1 while the 3rd bit is presented -> IDLE next cycle; outputs 0; no done pulse.
//  6. pat_valid held high during SEND -> pat_ready=0 until after done; the second request's MSB
//     appears 2 cycles after the done cycle. With SEQGEN_LFSR_FILL_EN, the gap bits match the
//     LFSR reference model from seed 8'hA5.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// Request channel plus serial line outputs of the bit-pattern transmitter.
// "master" is the request source and line consumer; "slave" is the transmitter.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             pat_valid;
  logic             pat_ready;
  logic [PAT_W-1:0] pat_data;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             output_bit;
  logic             bit_valid;
  logic             in_pattern;
  logic             done;
  logic             busy;
  logic [2:0]       present_state;

  modport master (
    output pat_valid, pat_data, repeat_cnt, gap_len,
    input  pat_ready, output_bit, bit_valid, in_pattern, done, busy, present_state
  );

  modport slave (
    input  pat_valid, pat_data, repeat_cnt, gap_len,
    output pat_ready, output_bit, bit_valid, in_pattern, done, busy, present_state
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: first bit one cycle after accept, MSB-first, repeats with gaps; ena=0 freezes all state.
// Accepts only in IDLE (pat_ready combinational); SEQGEN_LFSR_FILL_EN selects LFSR gap fill instead of zeros.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  seq_pattern_gen_if.slave bus
);

  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt_q;
  logic             obit_q;
  logic             bvld_q;
  logic             inpat_q;
  logic             done_q;
  logic             accept;
  logic             fill_first;
  logic             fill_next;

  assign bus.pat_ready     = (state_q == IDLE) & ena & ~rst;
  assign accept            = bus.pat_valid & bus.pat_ready;
  assign idx_d             = idx_q - 1'b1;
  assign bus.output_bit    = obit_q;
  assign bus.bit_valid     = bvld_q & ena;
  assign bus.in_pattern    = inpat_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.present_state = state_q;

`ifdef SEQGEN_LFSR_FILL_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // x^8+x^6+x^5+x^4+1, shifted MSB-out; one step per presented gap bit
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign fill_first = lfsr_q[7];
  assign fill_next  = lfsr_d[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else if (ena && state_q == GAP) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign fill_first = 1'b0;
  assign fill_next  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      obit_q  <= 1'b0;
      bvld_q  <= 1'b0;
      inpat_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pat_q   <= bus.pat_data;
            rep_q   <= bus.repeat_cnt;
            gap_q   <= bus.gap_len;
            idx_q   <= IDX_W'(PAT_W - 1);
            obit_q  <= bus.pat_data[PAT_W-1];
            bvld_q  <= 1'b1;
            inpat_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (idx_q != '0) begin
            idx_q  <= idx_d;
            obit_q <= pat_q[idx_d];
          end else if (rep_q != '0) begin
            rep_q <= rep_q - 1'b1;
            if (gap_q != '0) begin
              gcnt_q  <= gap_q - 1'b1;
              obit_q  <= fill_first;
              inpat_q <= 1'b0;
              state_q <= GAP;
            end else begin
              idx_q  <= IDX_W'(PAT_W - 1);
              obit_q <= pat_q[PAT_W-1];
            end
          end else begin
            obit_q  <= 1'b0;
            bvld_q  <= 1'b0;
            inpat_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        GAP: begin
          // gcnt_q counts fill bits still to come after the one on the line
          if (gcnt_q == '0) begin
            idx_q   <= IDX_W'(PAT_W - 1);
            obit_q  <= pat_q[PAT_W-1];
            inpat_q <= 1'b1;
            state_q <= SEND;
          end else begin
            gcnt_q <= gcnt_q - 1'b1;
            obit_q <= fill_next;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          obit_q  <= 1'b0;
          bvld_q  <= 1'b0;
          inpat_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Cycle-table bench for seq_pattern_gen: each row drives one cycle's inputs and checks that cycle's outputs.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  seq_pattern_gen_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

  seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ena;
    logic       vld;
    logic [3:0] dat;
    logic [7:0] rep;
    logic [3:0] gap;
    logic [7:0] exp;   // {output_bit, bit_valid, in_pattern, done, busy, state[2:0]}
    logic       rdy;
    logic       fill;  // output_bit is a gap fill bit taken from the model
  } vec_t;

  localparam logic [7:0] IDL  = 8'b0000_0000;
  localparam logic [7:0] S1   = 8'b1110_1001;
  localparam logic [7:0] S0   = 8'b0110_1001;
  localparam logic [7:0] G    = 8'b0100_1010;
  localparam logic [7:0] D    = 8'b0001_1011;
  localparam logic [7:0] STL0 = 8'b0010_1001;

  vec_t       vq[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] lfsr_m = 8'hA5;

  task automatic add(input logic r, input logic e, input logic v, input logic [3:0] d,
                     input logic [7:0] rp, input logic [3:0] g, input logic [7:0] x,
                     input logic rdy, input logic f);
    vec_t t;
    t.rst = r; t.ena = e; t.vld = v; t.dat = d; t.rep = rp; t.gap = g;
    t.exp = x; t.rdy = rdy; t.fill = f;
    vq.push_back(t);
  endtask

  task automatic next_fill(output logic b);
`ifdef SEQGEN_LFSR_FILL_EN
    b = lfsr_m[7];
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
    b = 1'b0;
`endif
  endtask

  function automatic logic [7:0] outs();
    return {bus.output_bit, bus.bit_valid, bus.in_pattern, bus.done, bus.busy, bus.present_state};
  endfunction

  initial begin
    logic [7:0] want;
    logic       fb;
    int         nb, np;
    logic       got_done;

    // reset, then first IDLE cycle
    add(1,1,0,4'h0,0,0,IDL,0,0);
    add(0,1,0,4'h0,0,0,IDL,1,0);
    // single pattern 1010, no repeat
    add(0,1,1,4'b1010,0,0,IDL,1,0);
    add(0,1,0,4'h0,0,0,S1,0,0); add(0,1,0,4'h0,0,0,S0,0,0);
    add(0,1,0,4'h0,0,0,S1,0,0); add(0,1,0,4'h0,0,0,S0,0,0);
    add(0,1,0,4'h0,0,0,D,0,0);  add(0,1,0,4'h0,0,0,IDL,1,0);
    // 1101, one repeat, two gap bits
    add(0,1,1,4'b1101,1,2,IDL,1,0);
    add(0,1,0,4'h0,0,0,S1,0,0); add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,S0,0,0); add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,G,0,1);  add(0,1,0,4'h0,0,0,G,0,1);
    add(0,1,0,4'h0,0,0,S1,0,0); add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,S0,0,0); add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,D,0,0);  add(0,1,0,4'h0,0,0,IDL,1,0);
    // 1010 with a 3-cycle ena stall on the 2nd bit
    add(0,1,1,4'b1010,0,0,IDL,1,0);
    add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,0,0,4'h0,0,0,STL0,0,0); add(0,0,0,4'h0,0,0,STL0,0,0); add(0,0,0,4'h0,0,0,STL0,0,0);
    add(0,1,0,4'h0,0,0,S0,0,0); add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,S0,0,0); add(0,1,0,4'h0,0,0,D,0,0);
    add(0,1,0,4'h0,0,0,IDL,1,0);
    // reset while the 3rd bit is on the line: no done pulse afterwards
    add(0,1,1,4'b1010,0,0,IDL,1,0);
    add(0,1,0,4'h0,0,0,S1,0,0); add(0,1,0,4'h0,0,0,S0,0,0);
    add(1,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,IDL,1,0); add(0,1,0,4'h0,0,0,IDL,1,0);
    // pat_valid held through SEND and DONE; second request accepted in the next IDLE
    add(0,1,1,4'b0110,0,0,IDL,1,0);
    add(0,1,1,4'b1001,0,0,S0,0,0); add(0,1,1,4'b1001,0,0,S1,0,0);
    add(0,1,1,4'b1001,0,0,S1,0,0); add(0,1,1,4'b1001,0,0,S0,0,0);
    add(0,1,1,4'b1001,0,0,D,0,0);
    add(0,1,1,4'b1001,0,0,IDL,1,0);
    add(0,1,0,4'h0,0,0,S1,0,0); add(0,1,0,4'h0,0,0,S0,0,0);
    add(0,1,0,4'h0,0,0,S0,0,0); add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,D,0,0);  add(0,1,0,4'h0,0,0,IDL,1,0);
    // 1111, one repeat, three gap bits
    add(0,1,1,4'b1111,1,3,IDL,1,0);
    for (int k = 0; k < 4; k++) add(0,1,0,4'h0,0,0,S1,0,0);
    for (int k = 0; k < 3; k++) add(0,1,0,4'h0,0,0,G,0,1);
    for (int k = 0; k < 4; k++) add(0,1,0,4'h0,0,0,S1,0,0);
    add(0,1,0,4'h0,0,0,D,0,0);  add(0,1,0,4'h0,0,0,IDL,1,0);

    rst = 1'b1; ena = 1'b1;
    bus.pat_valid = 1'b0; bus.pat_data = '0; bus.repeat_cnt = '0; bus.gap_len = '0;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; ena = vq[i].ena;
      bus.pat_valid = vq[i].vld; bus.pat_data = vq[i].dat;
      bus.repeat_cnt = vq[i].rep; bus.gap_len = vq[i].gap;
      @(negedge clk);
      want = vq[i].exp;
      if (vq[i].fill) begin
        next_fill(fb);
        want[7] = fb;
      end
      checks++;
      if (outs() !== want) begin
        errors++;
        $display("FAIL vec%0d outputs {bit,vld,inpat,done,busy,st}: got %b want %b", i, outs(), want);
      end
      checks++;
      if (bus.pat_ready !== vq[i].rdy) begin
        errors++;
        $display("FAIL vec%0d pat_ready: got %b want %b", i, bus.pat_ready, vq[i].rdy);
      end
      if (vq[i].rst) lfsr_m = 8'hA5;
      @(posedge clk); #1;
    end

    // 1001, two repeats, one gap bit: (2+1)*4 + 2*1 = 14 line bits
    rst = 1'b0; ena = 1'b1;
    bus.pat_valid = 1'b1; bus.pat_data = 4'b1001; bus.repeat_cnt = 8'd2; bus.gap_len = 4'd1;
    @(negedge clk);
    checks++;
    if (bus.pat_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst accept pat_ready: got %b want 1", bus.pat_ready);
    end
    @(posedge clk); #1;
    bus.pat_valid = 1'b0;
    nb = 0; np = 0; got_done = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (bus.bit_valid === 1'b1) nb++;
        if (bus.bit_valid === 1'b1 && bus.in_pattern === 1'b1) np++;
        if (bus.bit_valid === 1'b1 && bus.in_pattern === 1'b0) begin
          next_fill(fb);
          checks++;
          if (bus.output_bit !== fb) begin
            errors++;
            $display("FAIL burst fill bit: got %b want %b", bus.output_bit, fb);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL burst done timeout: got no done in 100 cycles want done");
    end
    checks++;
    if (nb != 14) begin
      errors++;
      $display("FAIL burst line bits: got %0d want 14", nb);
    end
    checks++;
    if (np != 12) begin
      errors++;
      $display("FAIL burst pattern bits: got %0d want 12", np);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.present_state !== 3'd0 || bus.pat_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst after done: got done=%b st=%0d rdy=%b want done=0 st=0 rdy=1",
               bus.done, bus.present_state, bus.pat_ready);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
